ddfs_iq_param: RTL and testbench

- Parametrised quadrature DDFS; successor to the fixed 2-bit I/Q DDFS.
- Programmable frequency control word (FCW), static phase offset, synchronous phase clear.
- Quarter-wave sine LUT with quadrant folding; signed OUT_W-bit I (cos) / Q (sin) outputs.
- Feeds the baseband mixer/modulator; replaces the fixed-frequency generator.

---
 rtl/ddfs_pkg.sv | 48 ++++
 rtl/ddfs_qw_lut.sv | 43 ++++
 rtl/ddfs_iq_param.sv | 130 +++++++++++++
 tb/tb_ddfs_iq_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared definitions for the parametrised quadrature DDFS.
//   quadrant_t   - phase quadrant encoding (top two truncated phase bits)
//   amplitude()  - peak output amplitude A = 2^(out_w-1)-1
//   quad_mirrors - true for quadrants whose LUT address is mirrored
//   lut_entry()  - elaboration-time quarter-wave sine table entry
package ddfs_pkg;

    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quadrant_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int amplitude(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

    // Quadrants 1 and 3 run the quarter wave backwards.
    function automatic logic quad_mirrors(input quadrant_t q);
        return (q == QUAD_1) || (q == QUAD_3);
    endfunction

    // Taylor series for sin(x); arguments stay inside (0, pi/2), where
    // ten terms are accurate far beyond the output resolution.
    function automatic real sin_approx(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 10; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // round(A * sin(2*pi*(k+0.5)/2^phase_w)); the half-sample offset makes
    // the mirrored quadrants land exactly on the same table entries.
    function automatic int lut_entry(input int k, input int phase_w, input int out_w);
        real x;
        x = 2.0 * PI * (real'(k) + 0.5) / real'(1 << phase_w);
        return $rtoi(real'(amplitude(out_w)) * sin_approx(x) + 0.5);
    endfunction

endpackage

// File: rtl/ddfs_qw_lut.sv
// ddfs_qw_lut: quarter-wave sine magnitude table with two registered read
// ports (one per I/Q path) sharing a single constant table.
//   clk, reset      - clock, async active-high reset (clears read registers)
//   addr_i, addr_q  - folded quarter-wave addresses
//   mag_i, mag_q    - unsigned magnitudes, one cycle after the address
module ddfs_qw_lut
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int OUT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PHASE_W-3:0] addr_i,
    input  logic [PHASE_W-3:0] addr_q,
    output logic [OUT_W-2:0]   mag_i,
    output logic [OUT_W-2:0]   mag_q
);

    localparam int DEPTH = 1 << (PHASE_W - 2);

    // NOTE: the table is a constant ROM built at elaboration; only the read
    // registers are reset, the table itself needs none.
    logic [OUT_W-2:0] rom [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int VAL = lut_entry(k, PHASE_W, OUT_W);
        assign rom[k] = (OUT_W-1)'(VAL);
    end

    // NOTE: sequential state is always written with non-blocking assignments
    // so every register samples its inputs from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mag_i <= '0;
            mag_q <= '0;
        end else begin
            mag_i <= rom[addr_i];
            mag_q <= rom[addr_q];
        end
    end

endmodule

// File: rtl/ddfs_iq_param.sv
// ddfs_iq_param: parametrised quadrature direct digital frequency synthesiser.
// A phase accumulator advanced by a programmable FCW is offset, truncated and
// folded onto a quarter-wave sine table to produce cos (I) and sin (Q).
//   clk, reset        - clock, async active-high reset
//   en                - advance the accumulator; marks the sample valid
//   fcw_in, fcw_load  - new frequency control word and its capture strobe
//   phase_off         - static phase offset added before truncation
//   phase_clr         - synchronous accumulator clear (wins over en)
//   Iout, Qout        - signed cosine / sine samples, 3 edges after sampling
//   out_valid         - sample came from an enabled, uncleared accumulator
module ddfs_iq_param
    import ddfs_pkg::*;
#(
    parameter int               ACC_W       = 16,
    parameter int               PHASE_W     = 8,
    parameter int               OUT_W       = 8,
    parameter logic [ACC_W-1:0] FCW_DEFAULT = 16'h0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [ACC_W-1:0]   fcw_in,
    input  logic               fcw_load,
    input  logic [ACC_W-1:0]   phase_off,
    input  logic               phase_clr,
    output logic [OUT_W-1:0]   Iout,
    output logic [OUT_W-1:0]   Qout,
    output logic               out_valid
);

    localparam logic [PHASE_W-1:0] QUARTER = PHASE_W'(1 << (PHASE_W - 2));

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   fcw_act;
    logic [PHASE_W-1:0] p_next;
    logic [PHASE_W-1:0] p_q;
    logic [PHASE_W-1:0] p_i;
    logic               v1;
    logic [PHASE_W-3:0] addr_q;
    logic [PHASE_W-3:0] addr_i;
    logic [OUT_W-2:0]   mag_q;
    logic [OUT_W-2:0]   mag_i;
    logic               neg_q2;
    logic               neg_i2;
    logic               v2;

    // Accumulator and FCW register. The accumulation on a load edge still
    // uses the old fcw_act; the new word takes effect one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc     <= '0;
            fcw_act <= FCW_DEFAULT;
        end else begin
            if (phase_clr)
                acc <= '0;
            else if (en)
                acc <= acc + fcw_act;
            if (fcw_load)
                fcw_act <= fcw_in;
        end
    end

    // Offset then keep only the top PHASE_W bits of the phase.
    assign p_next = PHASE_W'((acc + phase_off) >> (ACC_W - PHASE_W));

    // Stage 1: truncated phase; cosine is sine shifted a quarter turn ahead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q <= '0;
            p_i <= '0;
            v1  <= 1'b0;
        end else begin
            p_q <= p_next;
            p_i <= p_next + QUARTER;
            v1  <= en & ~phase_clr;
        end
    end

    // Quadrant folding. For mirrored quadrants 2^(PHASE_W-2)-1-a == ~a.
    // NOTE: every output of this block gets a default first, so no latch
    // can be inferred on any path.
    always_comb begin
        addr_q = p_q[PHASE_W-3:0];
        addr_i = p_i[PHASE_W-3:0];
        if (quad_mirrors(quadrant_t'(p_q[PHASE_W-1 -: 2])))
            addr_q = ~p_q[PHASE_W-3:0];
        if (quad_mirrors(quadrant_t'(p_i[PHASE_W-1 -: 2])))
            addr_i = ~p_i[PHASE_W-3:0];
    end

    // Stage 2: table lookup, with sign and valid piped alongside.
    ddfs_qw_lut #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .addr_i (addr_i),
        .addr_q (addr_q),
        .mag_i  (mag_i),
        .mag_q  (mag_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q2 <= 1'b0;
            neg_i2 <= 1'b0;
            v2     <= 1'b0;
        end else begin
            neg_q2 <= p_q[PHASE_W-1];
            neg_i2 <= p_i[PHASE_W-1];
            v2     <= v1;
        end
    end

    // Stage 3: apply sign. Magnitudes never exceed A, so the most negative
    // code cannot be produced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Iout      <= '0;
            Qout      <= '0;
            out_valid <= 1'b0;
        end else begin
            Iout      <= neg_i2 ? -{1'b0, mag_i} : {1'b0, mag_i};
            Qout      <= neg_q2 ? -{1'b0, mag_q} : {1'b0, mag_q};
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_ddfs_iq_param.sv
// tb_ddfs_iq_param: directed self-checking bench for ddfs_iq_param at the
// default parameters (ACC_W=16, PHASE_W=8, OUT_W=8, A=127).
module tb_ddfs_iq_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [15:0] fcw_in;
    logic        fcw_load;
    logic [15:0] phase_off;
    logic        phase_clr;
    logic [7:0]  Iout;
    logic [7:0]  Qout;
    logic        out_valid;

    int total = 0;
    int bad   = 0;

    // Reference pipeline: s1 = phase stage, s2 = lookup stage, s3 = output.
    // *_k marks a stage holding a sample taken after the last reset.
    logic [15:0] m_acc;
    logic [15:0] m_fcw;
    int s1_pq, s1_pi, s2_q, s2_i, s3_q, s3_i;
    bit s1_v, s2_v, s3_v, s1_k, s2_k, s3_k;

    ddfs_iq_param dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .fcw_in    (fcw_in),
        .fcw_load  (fcw_load),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .Iout      (Iout),
        .Qout      (Qout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Ideal sine sample with symmetric round-half-away rounding.
    function automatic int sine_ref(input int p);
        real m;
        m = 127.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 256.0);
        if (m >= 0.0)
            return $rtoi(m + 0.5);
        return -$rtoi(0.5 - m);
    endfunction

    task automatic model_reset();
        m_acc = 16'h0000;
        m_fcw = 16'h0100;
        s1_pq = 0; s1_pi = 0; s1_v = 0; s1_k = 0;
        s2_q  = 0; s2_i  = 0; s2_v = 0; s2_k = 0;
        s3_q  = 0; s3_i  = 0; s3_v = 0; s3_k = 0;
    endtask

    // Advance the model by one edge using the inputs the DUT will see,
    // then let the edge happen and compare against the model output.
    task automatic tick();
        logic [15:0] s;
        s3_q = s2_q; s3_i = s2_i; s3_v = s2_v; s3_k = s2_k;
        s2_q = sine_ref(s1_pq); s2_i = sine_ref(s1_pi); s2_v = s1_v; s2_k = s1_k;
        s = m_acc + phase_off;
        s1_pq = int'(s[15:8]);
        s1_pi = (s1_pq + 64) % 256;
        s1_v  = en && !phase_clr;
        s1_k  = 1;
        if (phase_clr)
            m_acc = 16'h0000;
        else if (en)
            m_acc = m_acc + m_fcw;
        if (fcw_load)
            m_fcw = fcw_in;
        @(posedge clk);
        #1;
        check("valid", int'(out_valid), int'(s3_v));
        if (s3_k) begin
            check("i_model", int'($signed(Iout)), s3_i);
            check("q_model", int'($signed(Qout)), s3_q);
        end
    endtask

    task automatic check_iq(input string tag, input int v, input int i, input int q);
        check({tag, "_valid"}, int'(out_valid), v);
        check({tag, "_i"}, int'($signed(Iout)), i);
        check({tag, "_q"}, int'($signed(Qout)), q);
    endtask

    initial begin
        int iv, qv, pw;
        reset = 1'b1; en = 1'b0; fcw_in = '0; fcw_load = 1'b0;
        phase_off = '0; phase_clr = 1'b0;
        model_reset();

        @(posedge clk);
        #1;
        check_iq("reset", 0, 0, 0);

        // Default FCW 0x0100: one table index per cycle, 3-edge latency.
        reset = 1'b0;
        en    = 1'b1;
        repeat (3) tick();
        check_iq("p0", 1, 127, 2);
        repeat (64) tick();
        check_iq("p64", 1, -2, 127);
        repeat (64) tick();
        check_iq("p128", 1, -127, -2);
        repeat (128) tick();
        check_iq("p256", 1, 127, 2);

        // Asynchronous reset in the middle of a cycle clears outputs at once.
        repeat (10) tick();
        reset = 1'b1;
        #2;
        check_iq("mid_reset", 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (3) tick();
        check_iq("after_reset", 1, 127, 2);

        // Load FCW 0x0200: old step on the load edge, double step afterwards.
        fcw_in   = 16'h0200;
        fcw_load = 1'b1;
        tick();
        fcw_load = 1'b0;
        repeat (40) tick();

        // Quarter-turn offset: Q at acc=0 equals the unoffset I at acc=0.
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        phase_off = 16'h4000;
        repeat (3) tick();
        check_iq("offset", 1, -2, 127);
        repeat (20) tick();

        // Disabled accumulator: held phase, out_valid low.
        en = 1'b0;
        repeat (6) tick();
        check("hold_valid", int'(out_valid), 0);

        // Clear plus enable at acc=0x7F00.
        phase_off = 16'h0000;
        fcw_in    = 16'h0100;
        fcw_load  = 1'b1;
        phase_clr = 1'b1;
        tick();
        fcw_load  = 1'b0;
        phase_clr = 1'b0;
        en        = 1'b1;
        repeat (127) tick();
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        repeat (2) tick();
        check("clr_valid", int'(out_valid), 0);
        tick();
        check_iq("clr_resume", 1, 127, 2);

        // FCW 0xFFFF over a full accumulator wrap: range and power bounds.
        fcw_in   = 16'hFFFF;
        fcw_load = 1'b1;
        tick();
        fcw_load = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            tick();
            iv = int'($signed(Iout));
            qv = int'($signed(Qout));
            pw = iv * iv + qv * qv;
            check("range_i", int'(iv >= -127 && iv <= 127), 1);
            check("range_q", int'(qv >= -127 && qv <= 127), 1);
            check("power", int'(pw >= 15484 && pw <= 16774), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
